sd_spi: RTL and testbench

SD_SPI -- requirements
Module: sd_spi

---
 rtl/sd_spi.sv | 158 +++++++++++++++
 tb/tb_sd_spi.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi.sv
// SPI mode-0 byte shifter for SD cards, clocked entirely from fclk.
// Ports: fclk/rst (sync, active-high), sd_start/sd_datain request a byte,
// sd_dataout/done return it, sdclk/sddo/sddi go to the card,
// busy covers shifting + pending, ovr flags a dropped request.
module sd_spi #(
    parameter int HALF = 2
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       sd_start,
    input  logic [7:0] sd_datain,
    output logic [7:0] sd_dataout,
    output logic       sdclk,
    output logic       sddo,
    input  logic       sddi,
    output logic       busy,
    output logic       done,
    output logic       ovr
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [3:0] PH_END = 4'(HALF - 1);

    state_t     state;
    state_t     state_nx;
    logic [3:0] phase;
    logic [2:0] bitcnt;
    logic [7:0] tx;
    logic [7:0] rx;
    logic [7:0] pend_data;
    logic       pend;

    logic tick;
    logic rise;
    logic fall;
    logic last;
    logic load;
    logic take_pend;
    logic take_new;

    always_comb begin
        state_nx  = state;
        tick      = 1'b0;
        rise      = 1'b0;
        fall      = 1'b0;
        last      = 1'b0;
        load      = 1'b0;
        take_pend = 1'b0;
        take_new  = 1'b0;
        unique case (state)
            IDLE: begin
                if (sd_start) begin
                    state_nx = SHIFT;
                    load     = 1'b1;
                end
            end
            SHIFT: begin
                tick = (phase == PH_END);
                rise = tick && !sdclk;
                fall = tick && sdclk;
                last = fall && (bitcnt == 3'd7);
                if (last) begin
                    if (pend) begin
                        take_pend = 1'b1;
                    end else if (sd_start) begin
                        take_new = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // tx refills with 1s as it shifts, so it reads 8'hFF whenever idle
    // and sddo can come straight from its MSB.
    always_ff @(posedge fclk) begin
        if (rst) begin
            phase      <= 4'd0;
            bitcnt     <= 3'd0;
            tx         <= 8'hFF;
            rx         <= 8'h00;
            pend       <= 1'b0;
            pend_data  <= 8'h00;
            sdclk      <= 1'b0;
            sd_dataout <= 8'hFF;
            done       <= 1'b0;
            ovr        <= 1'b0;
        end else begin
            done <= last;

            if (load || take_new) begin
                tx <= sd_datain;
            end else if (take_pend) begin
                tx <= pend_data;
            end else if (fall) begin
                tx <= {tx[6:0], 1'b1};
            end

            if (load) begin
                phase <= 4'd0;
            end else if (state == SHIFT) begin
                phase <= tick ? 4'd0 : phase + 4'd1;
            end

            if (tick) begin
                sdclk <= ~sdclk;
            end

            if (rise) begin
                rx <= {rx[6:0], sddi};
            end

            if (load) begin
                bitcnt <= 3'd0;
            end else if (fall) begin
                bitcnt <= bitcnt + 3'd1;
            end

            if (last) begin
                sd_dataout <= rx;
            end

            // A request arriving as the pending byte is consumed
            // takes over the freed pending slot.
            if (take_pend) begin
                pend <= sd_start;
                if (sd_start) begin
                    pend_data <= sd_datain;
                end
            end else if (state == SHIFT && sd_start && !take_new) begin
                if (pend) begin
                    ovr <= 1'b1;
                end else begin
                    pend      <= 1'b1;
                    pend_data <= sd_datain;
                end
            end
        end
    end

    assign sddo = tx[7];
    assign busy = (state == SHIFT) | pend;

endmodule

// File: tb/tb_sd_spi.sv
// Scoreboard bench for sd_spi: a transaction-level model predicts
// each byte's result and completion cycle; a monitor checks the DUT.
module tb_sd_spi;
    localparam int HALF = 2;
    localparam int T    = 16 * HALF;

    logic fclk = 1'b0;
    always #5 fclk = ~fclk;

    logic       rst;
    logic       sd_start;
    logic [7:0] sd_datain;
    logic [7:0] sd_dataout;
    logic       sdclk;
    logic       sddo;
    logic       sddi;
    logic       busy;
    logic       done;
    logic       ovr;
    int         mode;

    // 0: loopback, 1: inverted loopback, 2: tied low
    assign sddi = (mode == 0) ? sddo : (mode == 1) ? ~sddo : 1'b0;

    sd_spi #(.HALF(HALF)) dut (
        .fclk(fclk), .rst(rst), .sd_start(sd_start),
        .sd_datain(sd_datain), .sd_dataout(sd_dataout),
        .sdclk(sdclk), .sddo(sddo), .sddi(sddi),
        .busy(busy), .done(done), .ovr(ovr)
    );

    logic       s1_rst;
    logic       s1_start;
    logic [7:0] s1_data;
    logic [7:0] s1_dout;
    logic       s1_sdclk;
    logic       s1_sddo;
    logic       s1_busy;
    logic       s1_done;
    logic       s1_ovr;

    sd_spi #(.HALF(1)) u1 (
        .fclk(fclk), .rst(s1_rst), .sd_start(s1_start),
        .sd_datain(s1_data), .sd_dataout(s1_dout),
        .sdclk(s1_sdclk), .sddo(s1_sddo), .sddi(1'b0),
        .busy(s1_busy), .done(s1_done), .ovr(s1_ovr)
    );

    typedef struct {
        logic [7:0] d;
        int         at;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   run = 0;
    bit   d1_done = 0;

    bit   m_active = 0;
    bit   m_pend = 0;
    bit   m_ovr = 0;
    bit   m_rst_edge = 0;
    int   m_done_at = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rx_of(logic [7:0] b);
        case (mode)
            0:       return b;
            1:       return ~b;
            default: return 8'h00;
        endcase
    endfunction

    // One fclk edge: drive inputs, then advance the transaction model.
    task automatic step(bit st, logic [7:0] d, bit r);
        @(negedge fclk);
        sd_start  = st;
        sd_datain = d;
        rst       = r;
        @(posedge fclk);
        #1;
        cyc++;
        m_rst_edge = r;
        if (r) begin
            m_active = 0;
            m_pend   = 0;
            m_ovr    = 0;
            sbq.delete();
        end else begin
            if (m_active && cyc == m_done_at) begin
                if (m_pend) begin
                    m_pend    = 0;
                    m_done_at = m_done_at + T;
                end else begin
                    m_active = 0;
                end
            end
            if (st) begin
                if (!m_active) begin
                    m_active  = 1;
                    m_done_at = cyc + T;
                    sbq.push_back('{rx_of(d), m_done_at});
                end else if (m_pend) begin
                    m_ovr = 1;
                end else begin
                    m_pend = 1;
                    sbq.push_back('{rx_of(d), m_done_at + T});
                end
            end
        end
    endtask

    task automatic idle(int n);
        repeat (n) step(0, 8'h00, 0);
    endtask

    logic [7:0] last_dout = 8'hFF;
    int  hi_run = 0;
    int  lo_run = 0;
    bit  prev_sck = 0;
    bit  from_fall = 0;
    bit  exp_done;

    always @(negedge fclk) begin
        if (run) begin
            if (m_rst_edge) begin
                chk("dout_after_rst", sd_dataout, 8'hFF);
                last_dout = 8'hFF;
                hi_run    = 0;
                prev_sck  = 0;
                from_fall = 0;
            end
            exp_done = (sbq.size() > 0) && (sbq[0].at == cyc);
            chk("done", done, exp_done);
            if (done && sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("dout", sd_dataout, e.d);
                last_dout = e.d;
            end else begin
                chk("dout_hold", sd_dataout, last_dout);
            end
            chk("busy", busy, m_active || m_pend);
            chk("ovr", ovr, m_ovr);
            if (!m_active) begin
                chk("idle_sdclk", sdclk, 1'b0);
                chk("idle_sddo", sddo, 1'b1);
                from_fall = 0;
            end
            if (sdclk && !prev_sck && from_fall) begin
                chk("sck_low", lo_run, HALF);
            end
            if (!sdclk && prev_sck) begin
                chk("sck_high", hi_run, HALF);
                from_fall = 1;
                lo_run    = 0;
            end
            if (sdclk) begin
                hi_run++;
            end else begin
                hi_run = 0;
                lo_run++;
            end
            prev_sck = sdclk;
        end
    end

    initial begin
        int n;
        int hi;
        int pulses;
        int got;
        s1_rst   = 1;
        s1_start = 0;
        s1_data  = 8'h00;
        repeat (2) @(negedge fclk);
        s1_rst = 0;
        @(negedge fclk);
        s1_start = 1;
        s1_data  = 8'hFF;
        @(negedge fclk);
        s1_start = 0;
        n      = 0;
        hi     = 0;
        pulses = 0;
        got    = -1;
        while (n < 40) begin
            @(negedge fclk);
            n++;
            if (s1_sdclk) begin
                hi++;
            end else begin
                if (hi > 0) begin
                    chk("h1_sck_high", hi, 1);
                    pulses++;
                end
                hi = 0;
            end
            if (s1_done && got < 0) got = n;
        end
        chk("h1_done_at", got, 16);
        chk("h1_pulses", pulses, 8);
        chk("h1_dout", s1_dout, 8'h00);
        chk("h1_busy", s1_busy, 1'b0);
        d1_done = 1;
    end

    initial begin
        int budget;
        bit st;
        bit r;
        mode      = 0;
        rst       = 1;
        sd_start  = 0;
        sd_datain = 8'h00;
        step(1, 8'h55, 1);
        run = 1;
        step(0, 8'h00, 1);

        step(1, 8'hA5, 0);
        idle(T + 4);

        step(1, 8'h81, 0);
        idle(4);
        step(1, 8'h3C, 0);
        idle(3);
        step(1, 8'h77, 0);
        idle(2 * T + 4);
        step(0, 8'h00, 1);

        step(1, 8'h12, 0);
        idle(T - 1);
        step(1, 8'h34, 0);
        idle(T + 4);

        mode = 1;
        step(1, 8'hC3, 0);
        idle(9 * HALF);
        step(0, 8'h00, 1);
        idle(T + 4);

        mode = 2;
        step(1, 8'hFF, 0);
        idle(T + 2);

        for (int i = 0; i < 1500; i++) begin
            if (!m_active && !m_pend && $urandom_range(0, 7) == 0)
                mode = $urandom_range(0, 2);
            r  = ($urandom_range(0, 399) == 0);
            st = ($urandom_range(0, 9) == 0);
            step(st, 8'($urandom), r);
        end

        budget = 0;
        while (sbq.size() > 0 && budget < 4 * T) begin
            step(0, 8'h00, 0);
            budget++;
        end
        chk("drain_left", sbq.size(), 0);
        idle(2);
        chk("h1_finished", d1_done, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
